morse_tx_scheduler: RTL

- Shares one Morse output (LEDR lamp) among N_REQ requesters using round-robin arbitration.
- Each requester submits a 3-bit letter code (A–H) and holds it until acknowledged.
- The block then sequences the dot/dash/space timing for that letter, using an internal time-unit prescaler driven from CLOCK_50.
- It sits between the switch/key front end and the lamp, and replaces free-running pattern shifting with a handshaked transmitter.

---
 rtl/morse_tx_scheduler.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/morse_tx_scheduler.sv
// Round-robin Morse transmitter: arbitrates N_REQ letter requests and times dot/dash/space on one lamp.
// Optional `MORSE_SCHED_STATS_EN adds a 16-bit sent_count of completed letters.
module morse_tx_scheduler #(
  parameter int TICK_DIV = 25000000,
  parameter int N_REQ    = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [3*N_REQ-1:0]   letter,
  output logic [N_REQ-1:0]     ack,
  output logic [2:0]           grant_idx,
  output logic                 busy,
  output logic                 done,
  output logic                 morse_out
`ifdef MORSE_SCHED_STATS_EN
  ,
  output logic [15:0]          sent_count
`endif
);

  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] MARK  = 2'd1;
  localparam logic [1:0] SPACE = 2'd2;
  localparam logic [1:0] GAP   = 2'd3;

  logic [1:0]       state;
  logic [TW-1:0]    tick_cnt;
  logic [1:0]       unit_cnt;
  logic [1:0]       elem_idx;
  logic [1:0]       len_m1;
  logic [3:0]       dash_mask;
  logic [2:0]       last;

  logic [2:0]       winner;
  logic             found;
  int               best_rank;
  logic [2:0]       win_letter;
  logic [N_REQ-1:0] win_onehot;
  logic [1:0]       tbl_len_m1;
  logic [3:0]       tbl_dash;
  logic [1:0]       units_m1;
  logic             unit_end;
  logic             last_elem;

  // Rank each requester by its distance after the last winner; lowest pending rank wins.
  // NOTE: every always_comb output gets a default first, so no path can leave a latch behind.
  always_comb begin
    winner     = '0;
    win_letter = '0;
    best_rank  = N_REQ;
    for (int i = 0; i < N_REQ; i++) begin
      if (req[i] && (((i + N_REQ - int'(last) - 1) % N_REQ) < best_rank)) begin
        best_rank  = (i + N_REQ - int'(last) - 1) % N_REQ;
        winner     = 3'(i);
        win_letter = letter[3*i +: 3];
      end
    end
    found = (best_rank < N_REQ);
    for (int i = 0; i < N_REQ; i++) begin
      win_onehot[i] = found && (winner == 3'(i));
    end
  end

  // Element table: bit e of tbl_dash set means element e is a dash.
  always_comb begin
    tbl_len_m1 = 2'd0;
    tbl_dash   = 4'b0000;
    case (win_letter)
      3'd0: begin tbl_len_m1 = 2'd1; tbl_dash = 4'b0010; end  // A .-
      3'd1: begin tbl_len_m1 = 2'd3; tbl_dash = 4'b0001; end  // B -...
      3'd2: begin tbl_len_m1 = 2'd3; tbl_dash = 4'b0101; end  // C -.-.
      3'd3: begin tbl_len_m1 = 2'd2; tbl_dash = 4'b0001; end  // D -..
      3'd4: begin tbl_len_m1 = 2'd0; tbl_dash = 4'b0000; end  // E .
      3'd5: begin tbl_len_m1 = 2'd3; tbl_dash = 4'b0100; end  // F ..-.
      3'd6: begin tbl_len_m1 = 2'd2; tbl_dash = 4'b0011; end  // G --.
      default: begin tbl_len_m1 = 2'd3; tbl_dash = 4'b0000; end  // H ....
    endcase
  end

  always_comb begin
    units_m1 = 2'd0;
    case (state)
      MARK:    units_m1 = dash_mask[elem_idx] ? 2'd2 : 2'd0;
      GAP:     units_m1 = 2'd2;
      default: units_m1 = 2'd0;
    endcase
  end

  assign unit_end  = (tick_cnt == TICK_LAST) && (unit_cnt == units_m1);
  assign last_elem = (elem_idx == len_m1);

  assign busy      = (state != IDLE);
  assign morse_out = (state == MARK);
  assign done      = (state == GAP) && unit_end;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      ack       <= '0;
      grant_idx <= '0;
      last      <= 3'(N_REQ - 1);
      tick_cnt  <= '0;
      unit_cnt  <= '0;
      elem_idx  <= '0;
      len_m1    <= '0;
      dash_mask <= '0;
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            ack       <= win_onehot;
            grant_idx <= winner;
            last      <= winner;
            len_m1    <= tbl_len_m1;
            dash_mask <= tbl_dash;
            elem_idx  <= '0;
            tick_cnt  <= '0;
            unit_cnt  <= '0;
            state     <= MARK;
          end
        end
        default: begin
          if (unit_end) begin
            // Counters restart on every state entry so each duration is exact.
            tick_cnt <= '0;
            unit_cnt <= '0;
            case (state)
              MARK:    state <= last_elem ? GAP : SPACE;
              SPACE: begin
                elem_idx <= elem_idx + 2'd1;
                state    <= MARK;
              end
              default: state <= IDLE;
            endcase
          end else if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
            unit_cnt <= unit_cnt + 2'd1;
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
      endcase
    end
  end

`ifdef MORSE_SCHED_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sent_count <= '0;
    end else if (done) begin
      sent_count <= sent_count + 16'd1;
    end
  end
`endif

endmodule
